// File: rtl/mandelbrot_iter_ctrl_if.sv
// Bundle of the pixel-in, ALU and result ports of the Mandelbrot iteration sequencer.
// The controller uses the slave modport; the pixel source, ALU and colour mapper side uses master.
interface mandelbrot_iter_ctrl_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_cr;
   logic [WIDTH-1:0]     in_ci;
   logic [CNT_WIDTH-1:0] max_iter;
   logic                 flush;
   logic [WIDTH-1:0]     alu_cr;
   logic [WIDTH-1:0]     alu_ci;
   logic [WIDTH-1:0]     alu_zr;
   logic [WIDTH-1:0]     alu_zi;
   logic [WIDTH-1:0]     alu_out_zr;
   logic [WIDTH-1:0]     alu_out_zi;
   logic                 alu_size;
   logic                 alu_overflow;
   logic                 res_valid;
   logic                 res_ready;
   logic [CNT_WIDTH-1:0] res_count;
   logic                 res_escaped;
   logic                 busy;

   modport slave (
      input  in_valid, in_cr, in_ci, max_iter, flush,
      input  alu_out_zr, alu_out_zi, alu_size, alu_overflow, res_ready,
      output in_ready, alu_cr, alu_ci, alu_zr, alu_zi,
      output res_valid, res_count, res_escaped, busy
   );

   modport master (
      output in_valid, in_cr, in_ci, max_iter, flush,
      output alu_out_zr, alu_out_zi, alu_size, alu_overflow, res_ready,
      input  in_ready, alu_cr, alu_ci, alu_zr, alu_zi,
      input  res_valid, res_count, res_escaped, busy
   );
endinterface

// File: rtl/mandelbrot_iter_ctrl.sv
// Sequencer around a combinational z <- z^2 + c step: holds c and z, counts steps until
// the ALU reports escape or the per-pixel limit is reached, then offers the count.
module mandelbrot_iter_ctrl #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   mandelbrot_iter_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [WIDTH-1:0]     r_cr;
   logic [WIDTH-1:0]     r_ci;
   logic [WIDTH-1:0]     r_zr;
   logic [WIDTH-1:0]     r_zi;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_limit;
   logic [CNT_WIDTH-1:0] r_res_count;
   logic                 r_res_escaped;

   logic [CNT_WIDTH:0]   w_cnt_inc;
   logic                 w_at_limit;
   logic                 w_escape;

   // One extra bit so a limit of 2^CNT_WIDTH-1 is reached without the increment wrapping.
   assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign w_at_limit = (w_cnt_inc == {1'b0, r_limit});
   assign w_escape   = bus.alu_size | bus.alu_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_next = r_state;
      if (bus.flush) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  w_state_next = (bus.max_iter == '0) ? S_DONE : S_ITER;
               end
            end
            S_ITER: begin
               if (w_escape || w_at_limit) begin
                  w_state_next = S_DONE;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  w_state_next = S_IDLE;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
         r_cr          <= '0;
         r_ci          <= '0;
         r_zr          <= '0;
         r_zi          <= '0;
         r_cnt         <= '0;
         r_limit       <= '0;
         r_res_count   <= '0;
         r_res_escaped <= 1'b0;
      end else if (bus.flush) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_cr    <= bus.in_cr;
                  r_ci    <= bus.in_ci;
                  r_limit <= bus.max_iter;
                  r_zr    <= '0;
                  r_zi    <= '0;
                  r_cnt   <= '0;
                  if (bus.max_iter == '0) begin
                     r_res_count   <= '0;
                     r_res_escaped <= 1'b0;
                  end
               end
            end
            S_ITER: begin
               // Escape wins over the limit; on escape z is frozen at the escaping value.
               if (w_escape) begin
                  r_res_count   <= r_cnt;
                  r_res_escaped <= 1'b1;
               end else if (w_at_limit) begin
                  r_res_count   <= r_limit;
                  r_res_escaped <= 1'b0;
               end else begin
                  r_zr  <= bus.alu_out_zr;
                  r_zi  <= bus.alu_out_zi;
                  r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (r_state == S_IDLE);
   assign bus.res_valid   = (r_state == S_DONE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.alu_cr      = r_cr;
   assign bus.alu_ci      = r_ci;
   assign bus.alu_zr      = r_zr;
   assign bus.alu_zi      = r_zi;
   assign bus.res_count   = r_res_count;
   assign bus.res_escaped = r_res_escaped;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Bench for mandelbrot_iter_ctrl: a behavioural ALU (real 2.6 fixed point or a counting stub)
// drives the DUT, and an iteration model predicts count, escape flag and latency per pixel.
module tb_mandelbrot_iter_ctrl;

   localparam int MODE_REAL = 0;
   localparam int MODE_OVF  = 1;
   localparam int MODE_SIZE = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   alu_mode = MODE_REAL;
   int   stub_hit = -1;

   mandelbrot_iter_ctrl_if #(.WIDTH(8), .CNT_WIDTH(8)) bus ();

   mandelbrot_iter_ctrl #(.WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wrap8(input int v);
      int m;
      m = v & 255;
      return (m >= 128) ? m - 256 : m;
   endfunction

   // One ALU step. Real mode: Q2.6 arithmetic, size = |z|^2 > 4, overflow = next z out of range.
   // Stub modes: next z = (zr+1, zi), flag raised when zr equals stub_hit.
   function automatic void alu_step(input int mode, input int hit, input int zr, input int zi,
                                    input int cr, input int ci,
                                    output int nzr, output int nzi, output bit sz, output bit ov);
      if (mode == MODE_REAL) begin
         sz  = (zr * zr + zi * zi) > 16384;
         nzr = ((zr * zr - zi * zi) >>> 6) + cr;
         nzi = ((2 * zr * zi) >>> 6) + ci;
         ov  = (nzr > 127) || (nzr < -128) || (nzi > 127) || (nzi < -128);
      end else begin
         nzr = zr + 1;
         nzi = zi;
         sz  = (mode == MODE_SIZE) && (zr == hit);
         ov  = (mode == MODE_OVF) && (zr == hit);
      end
   endfunction

   always_comb begin : alu_model
      int nzr, nzi;
      bit sz, ov;
      alu_step(alu_mode, stub_hit, int'($signed(bus.alu_zr)), int'($signed(bus.alu_zi)),
               int'($signed(bus.alu_cr)), int'($signed(bus.alu_ci)), nzr, nzi, sz, ov);
      bus.alu_out_zr   = 8'(nzr);
      bus.alu_out_zi   = 8'(nzi);
      bus.alu_size     = sz;
      bus.alu_overflow = ov;
   end

   // Orbit of z from 0: first step index that escapes, or the limit; latency counted in
   // clock edges from the accepting edge (inclusive) to the edge that raises res_valid.
   function automatic void model(input int mode, input int hit, input int cr, input int ci,
                                 input int mi, output int cnt, output int esc, output int lat);
      int zr, zi, nzr, nzi;
      bit sz, ov;
      zr = 0;
      zi = 0;
      cnt = 0; esc = 0; lat = 1;
      if (mi == 0) return;
      for (int n = 0; n < 256; n++) begin
         alu_step(mode, hit, zr, zi, cr, ci, nzr, nzi, sz, ov);
         if (sz || ov) begin
            cnt = n; esc = 1; lat = n + 2;
            return;
         end
         if (n + 1 == mi) begin
            cnt = mi; esc = 0; lat = mi + 1;
            return;
         end
         zr = wrap8(nzr);
         zi = wrap8(nzi);
      end
   endfunction

   task automatic run_pixel(input int mode, input int hit, input int cr, input int ci,
                            input int mi, input int stall,
                            output int o_cnt, output int o_esc, output int o_lat);
      int  e_cnt, e_esc, e_lat, k;
      bit  got;
      alu_mode = mode;
      stub_hit = hit;
      model(mode, hit, wrap8(cr), wrap8(ci), mi, e_cnt, e_esc, e_lat);
      check("ready_before_accept", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_cr    = 8'(cr);
      bus.in_ci    = 8'(ci);
      bus.max_iter = 8'(mi);
      k   = 0;
      got = 1'b0;
      while (!got && k < 400) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (bus.res_valid) begin
            got = 1'b1;
            bus.in_valid = 1'b0;
         end else begin
            check("in_ready_low_iter", 32'(bus.in_ready), 0);
            check("busy_iter", 32'(bus.busy), 1);
            // Garbage on the input side while busy must not disturb the pixel.
            bus.in_cr    = 8'($urandom);
            bus.in_ci    = 8'($urandom);
            bus.max_iter = 8'($urandom);
         end
      end
      if (!got) check("result_timeout", 0, 1);
      o_cnt = int'(bus.res_count);
      o_esc = int'(bus.res_escaped);
      o_lat = k;
      check("latency", 32'(k), 32'(e_lat));
      check("res_count", 32'(bus.res_count), 32'(e_cnt));
      check("res_escaped", 32'(bus.res_escaped), 32'(e_esc));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_valid", 32'(bus.res_valid), 1);
         check("stall_count", 32'(bus.res_count), 32'(e_cnt));
         check("stall_escaped", 32'(bus.res_escaped), 32'(e_esc));
         check("stall_in_ready", 32'(bus.in_ready), 0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("after_hs_valid", 32'(bus.res_valid), 0);
      check("after_hs_ready", 32'(bus.in_ready), 1);
      check("after_hs_busy", 32'(bus.busy), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
      check({tag, "_res_count"}, 32'(bus.res_count), 0);
      check({tag, "_res_escaped"}, 32'(bus.res_escaped), 0);
      check({tag, "_alu_z"}, {16'd0, bus.alu_zr, bus.alu_zi}, 0);
      check({tag, "_alu_c"}, {16'd0, bus.alu_cr, bus.alu_ci}, 0);
   endtask

   initial begin
      int c, e, l;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_cr     = '0;
      bus.in_ci     = '0;
      bus.max_iter  = '0;
      bus.flush     = 1'b0;
      bus.res_ready = 1'b0;
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // c = 0 never escapes: full limit.
      run_pixel(MODE_REAL, -1, 0, 0, 10, 0, c, e, l);
      check("tp1_count", 32'(c), 10);
      check("tp1_escaped", 32'(e), 0);
      check("tp1_latency", 32'(l), 11);

      run_pixel(MODE_OVF, 3, 0, 0, 20, 0, c, e, l);
      check("tp2_count", 32'(c), 3);
      check("tp2_escaped", 32'(e), 1);
      check("tp2_latency", 32'(l), 5);

      // Escape and limit coincide; escape wins.
      run_pixel(MODE_SIZE, 3, 0, 0, 4, 0, c, e, l);
      check("tp3_count", 32'(c), 3);
      check("tp3_escaped", 32'(e), 1);

      run_pixel(MODE_REAL, -1, 5, 7, 0, 0, c, e, l);
      check("tp4_count", 32'(c), 0);
      check("tp4_escaped", 32'(e), 0);
      check("tp4_latency", 32'(l), 1);
      check("tp4_cnt_unused", 32'(bus.alu_zr), 0);

      // Backpressure, then immediate re-accept after the bubble.
      run_pixel(MODE_REAL, -1, 8'h20, 8'hE0, 12, 5, c, e, l);
      run_pixel(MODE_REAL, -1, 8'h90, 8'h10, 15, 0, c, e, l);

      // Largest limit: the counter must not wrap.
      run_pixel(MODE_REAL, -1, 0, 0, 255, 0, c, e, l);
      check("maxlim_count", 32'(c), 255);
      check("maxlim_latency", 32'(l), 256);

      // Flush at cnt == 2; flush also blocks an accept while idle.
      alu_mode     = MODE_OVF;
      stub_hit     = -1;
      bus.in_valid = 1'b1;
      bus.in_cr    = 8'h11;
      bus.in_ci    = 8'h22;
      bus.max_iter = 8'd20;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      check("flush_pre_cnt", 32'(bus.alu_zr), 2);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("flush_idle", 32'(bus.in_ready), 1);
      check("flush_no_valid", 32'(bus.res_valid), 0);
      @(posedge clk);
      @(negedge clk);
      check("flush_blocks_accept", 32'(bus.busy), 0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.res_valid) check("flush_dropped_result", 32'(bus.res_valid), 0);
      end
      check("flush_quiet", 32'(bus.res_valid | bus.busy), 0);

      // Reset in the middle of an iteration.
      alu_mode     = MODE_REAL;
      bus.in_valid = 1'b1;
      bus.in_cr    = 8'h08;
      bus.in_ci    = 8'h04;
      bus.max_iter = 8'd30;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      check("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_no_valid", 32'(bus.res_valid), 0);
      run_pixel(MODE_REAL, -1, 0, 0, 3, 0, c, e, l);

      // Randomized pixels across ALU modes, limits and backpressure.
      for (int t = 0; t < 40; t++) begin
         int mode, hit, mi;
         mode = $urandom_range(0, 2);
         hit  = $urandom_range(0, 40);
         mi   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         run_pixel(mode, hit, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   mi, $urandom_range(0, 3), c, e, l);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mandelbrot_iter_ctrl.md
Name: mandelbrot_iter_ctrl

Overview:
- Sequencer for one combinational Mandelbrot ALU step block (one z ← z² + c step per cycle).
- Accepts one pixel coordinate c = (cr, ci) over a valid/ready handshake.
- Holds the iterate z in registers and feeds it to the ALU each cycle.
- Counts iterations until the ALU flags escape (size or overflow) or a runtime iteration limit is hit, then presents the count over a second valid/ready handshake.
- Sits between the pixel scan generator and the colour mapper.

Parameters:
WIDTH, 8, bit width of cr/ci/zr/zi, signed fixed point 2.(WIDTH-2)
CNT_WIDTH, 8, bit width of iteration counter and max_iter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  pixel coordinate valid
in_ready  output  1  controller can accept a coordinate
in_cr  input  WIDTH  real part of c
in_ci  input  WIDTH  imaginary part of c
max_iter  input  CNT_WIDTH  iteration limit, sampled at accept
flush  input  1  synchronous abort, return to IDLE
alu_cr  output  WIDTH  c real to ALU (latched)
alu_ci  output  WIDTH  c imag to ALU (latched)
alu_zr  output  WIDTH  current z real to ALU
alu_zi  output  WIDTH  current z imag to ALU
alu_out_zr  input  WIDTH  next z real from ALU
alu_out_zi  input  WIDTH  next z imag from ALU
alu_size  input  1  ALU: |z|² > 4 for current z
alu_overflow  input  1  ALU: next z not representable
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_count  output  CNT_WIDTH  iterations completed before escape or limit
res_escaped  output  1  1 = escaped, 0 = limit reached
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - zr, zi, cr, ci, cnt, limit, res_count, res_escaped = 0.
  - res_valid=0, in_ready=1, busy=0.
- States: IDLE, ITER, DONE (2-bit encoded). in_ready = (state==IDLE). res_valid = (state==DONE). busy = (state!=IDLE).
- ALU outputs alu_cr/ci/zr/zi are driven directly from registers; no combinational path from in_* to alu_*.
- IDLE: when in_valid=1, accept the coordinate:
  - cr←in_cr, ci←in_ci, limit←max_iter, zr←0, zi←0, cnt←0.
  - If max_iter==0: go to DONE with res_count=0, res_escaped=0.
  - Otherwise go to ITER.
- ITER, one ALU step per cycle, evaluated on the registered z = z_cnt:
  - If alu_size | alu_overflow: res_count←cnt, res_escaped←1, go to DONE. z is not updated.
  - Else if cnt+1 == limit: res_count←limit, res_escaped←0, go to DONE.
  - Else: zr←alu_out_zr, zi←alu_out_zi, cnt←cnt+1, stay in ITER.
  - Escape takes priority over the limit in the same cycle.
- Latency from accept to res_valid:
  - Non-escaping pixel: limit+1 cycles.
  - Pixel escaping at count n: n+2 cycles.
  - max_iter==0: 1 cycle.
- Counter: cnt+1 is compared at CNT_WIDTH+1 bits, so there is no wrap. A limit of 2^CNT_WIDTH−1 is the maximum.
- DONE: res_count and res_escaped are held stable while res_valid=1. When res_ready=1, go to IDLE. A new coordinate can be accepted the cycle after the result handshake, giving 1 bubble cycle.
- flush=1 has priority over all transitions in any state:
  - Next state is IDLE and cnt←0.
  - The pending result is dropped; res_valid falls next cycle.
  - In IDLE, flush blocks an accept in the same cycle.
- Changes to in_* and max_iter outside IDLE are ignored.
- rst asserted mid-ITER or mid-DONE: immediate return to reset values; no result is emitted.

Test Plan:
- Real ALU, WIDTH=8, c=(0x00,0x00), max_iter=10 → after accept, res_valid at cycle 11, res_count=10, res_escaped=0; in_ready low throughout.
- Stub ALU asserting alu_overflow when cnt==3, max_iter=20 → res_count=3, res_escaped=1, res_valid at cycle 5 after accept.
- Stub ALU asserting alu_size and reaching the limit in the same cycle (max_iter=4, size at cnt=3) → res_escaped=1, res_count=3.
- max_iter=0 with in_valid pulse → res_valid next cycle, res_count=0, res_escaped=0, alu never used (cnt=0).
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_count/res_escaped stable, in_ready=0; raise res_ready → IDLE next cycle; a new in_valid is accepted on the following cycle.
- flush at cnt=2 in ITER, then rst pulse during a later ITER → IDLE next cycle with no res_valid, and all outputs at reset values immediately on rst.
